// File: rtl/div_mon_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
package div_mon_pkg;

   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned GOOD_W    = 4;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      IN_HIGH   = 2'd1,
      IN_LOW    = 2'd2
   } mon_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for signals crossing into the clk domain.
module sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/div_period_monitor.sv
// Measures high/low durations of a slow square wave, checks each full period
// against expected values and asserts locked after a run of good periods.
module div_period_monitor
   import div_mon_pkg::*;
#(
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned TOL      = 0,
   parameter int unsigned LOCK_CNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic [CNT_W-1:0] exp_high,
   input  logic [CNT_W-1:0] exp_low,
   output logic [CNT_W-1:0] high_len,
   output logic [CNT_W-1:0] low_len,
   output logic             period_valid,
   output logic             err,
   output logic             locked
);

   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W:0]    TOL_X   = (CNT_W+1)'(TOL);
   localparam logic [GOOD_W-1:0] LOCK_V  = GOOD_W'(LOCK_CNT);

   function automatic logic [CNT_W:0] f_absdiff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] ea;
      logic [CNT_W:0] eb;
      ea = (CNT_W+1)'(a);
      eb = (CNT_W+1)'(b);
      return (ea >= eb) ? (ea - eb) : (eb - ea);
   endfunction

   logic              w_s2;
   logic              r_s3;
   logic [CNT_W-1:0]  r_run_cnt;
   mon_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_high_len, w_high_len_nxt;
   logic [CNT_W-1:0]  r_low_len, w_low_len_nxt;
   logic              r_period_valid, w_period_valid_nxt;
   logic              r_err, w_err_nxt;
   logic              r_locked, w_locked_nxt;
   logic [GOOD_W-1:0] r_good_cnt, w_good_cnt_nxt;
   logic              r_high_ok;
   logic              w_edge, w_rise, w_fall, w_timeout, w_low_ok, w_good;

   sync2 #(.W(1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (sig_in),
      .o_q   (w_s2)
   );

   assign w_edge    = w_s2 ^ r_s3;
   assign w_rise    = w_s2 & ~r_s3;
   assign w_fall    = ~w_s2 & r_s3;
   assign w_timeout = (r_run_cnt == CNT_MAX) && !w_edge && (r_state != WAIT_RISE);
   assign w_low_ok  = (r_run_cnt != CNT_MAX) && (f_absdiff(r_run_cnt, exp_low) <= TOL_X);
   assign w_good    = r_high_ok & w_low_ok;

   // Edge history and level-length counter; the high check lags capture by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s3      <= 1'b0;
         r_run_cnt <= '0;
         r_high_ok <= 1'b0;
      end else begin
         r_s3      <= w_s2;
         r_high_ok <= (r_high_len != CNT_MAX) && (f_absdiff(r_high_len, exp_high) <= TOL_X);
         if (w_edge)
            r_run_cnt <= CNT_W'(1);
         else if (r_run_cnt != CNT_MAX)
            r_run_cnt <= r_run_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= WAIT_RISE;
         r_high_len     <= '0;
         r_low_len      <= '0;
         r_period_valid <= 1'b0;
         r_err          <= 1'b0;
         r_locked       <= 1'b0;
         r_good_cnt     <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_high_len     <= w_high_len_nxt;
         r_low_len      <= w_low_len_nxt;
         r_period_valid <= w_period_valid_nxt;
         r_err          <= w_err_nxt;
         r_locked       <= w_locked_nxt;
         r_good_cnt     <= w_good_cnt_nxt;
      end
   end

   // An edge takes priority over a timeout because the captured count is still valid
   always_comb begin
      w_state_nxt        = r_state;
      w_high_len_nxt     = r_high_len;
      w_low_len_nxt      = r_low_len;
      w_period_valid_nxt = 1'b0;
      w_err_nxt          = 1'b0;
      w_good_cnt_nxt     = r_good_cnt;
      case (r_state)
         WAIT_RISE: begin
            if (w_rise)
               w_state_nxt = IN_HIGH;
         end
         IN_HIGH: begin
            if (w_fall) begin
               w_high_len_nxt = r_run_cnt;
               w_state_nxt    = IN_LOW;
            end else if (w_timeout) begin
               w_err_nxt      = 1'b1;
               w_good_cnt_nxt = '0;
               w_state_nxt    = WAIT_RISE;
            end
         end
         IN_LOW: begin
            if (w_rise) begin
               w_low_len_nxt      = r_run_cnt;
               w_period_valid_nxt = 1'b1;
               w_state_nxt        = IN_HIGH;
               if (w_good) begin
                  if (r_good_cnt != LOCK_V)
                     w_good_cnt_nxt = r_good_cnt + GOOD_W'(1);
               end else begin
                  w_good_cnt_nxt = '0;
                  w_err_nxt      = 1'b1;
               end
            end else if (w_timeout) begin
               w_err_nxt      = 1'b1;
               w_good_cnt_nxt = '0;
               w_state_nxt    = WAIT_RISE;
            end
         end
         default: w_state_nxt = WAIT_RISE;
      endcase
      w_locked_nxt = (w_good_cnt_nxt == LOCK_V);
   end

   assign high_len     = r_high_len;
   assign low_len      = r_low_len;
   assign period_valid = r_period_valid;
   assign err          = r_err;
   assign locked       = r_locked;

endmodule

// File: tb/tb_div_period_monitor.sv
// Drives random and directed square waves into two monitor instances (8-bit
// exact-match and 4-bit tolerant) and checks every reported event against a
// level-by-level reference model.
module tb_div_period_monitor;

   localparam int LOCK = 4;
   localparam int P_WAIT = 0, P_HIGH = 1, P_LOW = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sig_in;
   logic [7:0] exp_high_a, exp_low_a, high_len_a, low_len_a;
   logic [3:0] exp_high_b, exp_low_b, high_len_b, low_len_b;
   logic       pv_a, err_a, lk_a, pv_b, err_b, lk_b;

   always #5 clk = ~clk;

   div_period_monitor #(.CNT_W(8), .TOL(0), .LOCK_CNT(LOCK)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
      .exp_high(exp_high_a), .exp_low(exp_low_a),
      .high_len(high_len_a), .low_len(low_len_a),
      .period_valid(pv_a), .err(err_a), .locked(lk_a)
   );

   div_period_monitor #(.CNT_W(4), .TOL(1), .LOCK_CNT(LOCK)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
      .exp_high(exp_high_b), .exp_low(exp_low_b),
      .high_len(high_len_b), .low_len(low_len_b),
      .period_valid(pv_b), .err(err_b), .locked(lk_b)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Expected event: either a completed period or a timeout
   typedef struct {
      bit tmo;
      int hl;
      int ll;
      bit err;
      bit lock;
      int at;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];

   int phase [2];
   int gc    [2];
   int hpend [2];
   int prev_len;

   function automatic int maxv(input int d);
      return (d == 0) ? 255 : 15;
   endfunction

   function automatic int tolv(input int d);
      return (d == 0) ? 0 : 1;
   endfunction

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   task automatic push_ev(input int d, input ev_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         phase[d] = P_WAIT;
         gc[d]    = 0;
         hpend[d] = 0;
      end
      prev_len = 0;
   endtask

   // Called when a new level of value v and length len starts at cycle c0
   task automatic model_level(input bit v, input int len, input int c0);
      for (int d = 0; d < 2; d++) begin
         int  eh, el;
         bit  good;
         ev_t e;
         eh = (d == 0) ? int'(exp_high_a) : int'(exp_high_b);
         el = (d == 0) ? int'(exp_low_a)  : int'(exp_low_b);
         if (v) begin
            if (phase[d] == P_LOW) begin
               good = (hpend[d] != maxv(d)) && (prev_len != maxv(d)) &&
                      (iabs(hpend[d] - eh) <= tolv(d)) && (iabs(prev_len - el) <= tolv(d));
               gc[d]  = good ? ((gc[d] < LOCK) ? gc[d] + 1 : LOCK) : 0;
               e.tmo  = 1'b0;
               e.hl   = hpend[d];
               e.ll   = prev_len;
               e.err  = !good;
               e.lock = (gc[d] == LOCK);
               e.at   = c0 + 3;
               push_ev(d, e);
            end
            phase[d] = P_HIGH;
         end else if (phase[d] == P_HIGH) begin
            hpend[d] = prev_len;
            phase[d] = P_LOW;
         end
         if (phase[d] != P_WAIT && len > maxv(d)) begin
            gc[d]    = 0;
            phase[d] = P_WAIT;
            e.tmo  = 1'b1;
            e.hl   = 0;
            e.ll   = 0;
            e.err  = 1'b1;
            e.lock = 1'b0;
            e.at   = c0 + maxv(d) + 3;
            push_ev(d, e);
         end
      end
      prev_len = len;
   endtask

   // Entered and left just after a rising clk edge
   task automatic drive_level(input bit v, input int len);
      sig_in = v;
      model_level(v, len, cyc);
      repeat (len) @(posedge clk);
      #1;
   endtask

   task automatic period(input int h, input int l);
      drive_level(1'b1, h);
      drive_level(1'b0, l);
   endtask

   task automatic set_exp(input int h, input int l);
      exp_high_a = 8'(h);
      exp_low_a  = 8'(l);
      exp_high_b = 4'(h);
      exp_low_b  = 4'(l);
   endtask

   task automatic mon(input int d, input logic pv, input logic er, input logic lk,
                      input logic [31:0] hl, input logic [31:0] ll);
      ev_t   e;
      string n;
      n = (d == 0) ? "a" : "b";
      if (pv || er) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk_eq({n, "_unexpected_event"}, 32'(1), 32'(0));
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk_eq({n, "_event_cycle"}, 32'(cyc), 32'(e.at));
            chk_eq({n, "_period_valid"}, 32'(pv), 32'(!e.tmo));
            chk_eq({n, "_err"}, 32'(er), 32'(e.err));
            chk_eq({n, "_locked"}, 32'(lk), 32'(e.lock));
            if (!e.tmo) begin
               chk_eq({n, "_high_len"}, hl, 32'(e.hl));
               chk_eq({n, "_low_len"}, ll, 32'(e.ll));
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         mon(0, pv_a, err_a, lk_a, 32'(high_len_a), 32'(low_len_a));
         mon(1, pv_b, err_b, lk_b, 32'(high_len_b), 32'(low_len_b));
      end
   end

   task automatic chk_outputs_zero(input string tag);
      chk_eq({tag, "_a"}, 32'({high_len_a, low_len_a, pv_a, err_a, lk_a}), 32'(0));
      chk_eq({tag, "_b"}, 32'({high_len_b, low_len_b, pv_b, err_b, lk_b}), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n  = 1'b0;
      sig_in = 1'b0;
      set_exp(6, 6);
      model_reset();

      // Reset held with the input toggling
      repeat (5) begin
         @(posedge clk); #1 sig_in = ~sig_in;
         @(negedge clk);
         chk_outputs_zero("reset_hold");
      end
      sig_in = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Nominal 6/6 wave, lock on the fourth period
      repeat (8) period(6, 6);

      // One skewed period, then relock
      period(7, 5);
      repeat (5) period(6, 6);

      // Stuck high long enough to time out the 4-bit instance
      drive_level(1'b1, 40);
      drive_level(1'b0, 6);
      repeat (5) period(6, 6);

      // Reset while in the low half and locked
      drive_level(1'b1, 6);
      drive_level(1'b0, 3);
      chk_eq("pre_reset_locked_a", 32'(lk_a), 32'(1));
      chk_eq("pre_reset_locked_b", 32'(lk_b), 32'(1));
      chk_eq("pre_reset_queue_a", 32'(q0.size()), 32'(0));
      chk_eq("pre_reset_queue_b", 32'(q1.size()), 32'(0));
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("async_reset");
      model_reset();
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      repeat (6) period(6, 6);

      // Jittered 9/9 wave
      set_exp(9, 9);
      repeat (30) period(8 + $urandom_range(0, 2), 8 + $urandom_range(0, 2));
      chk_eq("jitter_lock_held_b", 32'(lk_b), 32'(1));

      // Random lengths and expectations, including saturation and timeouts on the 4-bit instance
      repeat (4) begin
         set_exp($urandom_range(3, 14), $urandom_range(3, 14));
         repeat (8) period($urandom_range(3, 20), $urandom_range(3, 20));
      end

      drive_level(1'b1, 10);
      chk_eq("final_queue_a", 32'(q0.size()), 32'(0));
      chk_eq("final_queue_b", 32'(q1.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/div_period_monitor.md
# div_period_monitor

Receive-side checker for divided clocks. It samples a slow square wave (for example the output of a divide-by-N, 50%-duty clock divider) with the fast system clock and measures the high and low durations of every full period. Each period is compared against programmed expectations, and `locked` is asserted after a run of consecutive good periods. It sits at the consuming end of the divider and serves as the on-chip self-check that the divided clock has the intended ratio and duty cycle.

## Interface
- `CNT_W`, default 8: width of the duration counters and expectation inputs.
- `TOL`, default 0: allowed absolute deviation (in clk cycles) of each measured half-period.
- `LOCK_CNT`, default 4: consecutive good periods required to assert `locked`; legal range 1..15.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sig_in`  in  1: monitored square wave, asynchronous to `clk`.
- `exp_high`  in  CNT_W: expected high duration in clk cycles; quasi-static.
- `exp_low`  in  CNT_W: expected low duration in clk cycles; quasi-static.
- `high_len`  out  CNT_W: last completed high duration.
- `low_len`  out  CNT_W: last completed low duration.
- `period_valid`  out  1: one-cycle pulse when a full period completes.
- `err`  out  1: one-cycle pulse on a bad period or a timeout.
- `locked`  out  1: level, asserted after LOCK_CNT consecutive good periods.

## Operation
- Input path: 2-flop synchronizer (`s1`, `s2`) followed by a history flop `s3`. Edge when `s2 != s3`; rising edge when `s2 & ~s3`.
- `run_cnt` (CNT_W bits):
  - On an edge cycle it holds the length of the level that just ended, then loads 1.
  - Otherwise it increments and saturates at all-ones.
- FSM states and transitions:
  - WAIT_RISE (reset state): ignore everything until the first rising edge, then go to IN_HIGH. The partial first level is discarded.
  - IN_HIGH: on a falling edge, `high_len <= run_cnt`, go to IN_LOW.
  - IN_LOW: on a rising edge, `low_len <= run_cnt`, pulse `period_valid`, evaluate the period, go to IN_HIGH.
  - In IN_HIGH or IN_LOW, if `run_cnt` reaches all-ones with no edge (timeout): pulse `err`, clear lock state, go to WAIT_RISE.
- Good period: both `|high_len - exp_high| <= TOL` and `|low_len - exp_low| <= TOL`, and neither value is saturated. Differences are computed unsigned at CNT_W+1 bits.
- Evaluation is done on the new values. `high_len` is compared the cycle after capture; the comparison is pipelined so that `period_valid`, `err` and `locked` update in the same cycle.
- Lock counter `good_cnt` (4 bits):
  - Good period: increment, saturating at LOCK_CNT.
  - Bad period: clear to 0 and pulse `err`.
  - `locked = (good_cnt == LOCK_CNT)`, registered.
- `exp_*` changes take effect at the next evaluation. The lock is not cleared until a bad period occurs.

## Timing
- Reset values: `high_len` = 0, `low_len` = 0, `period_valid` = 0, `err` = 0, `locked` = 0, `good_cnt` = 0, synchronizer flops = 0, state = WAIT_RISE.
- Latency:
  - A `sig_in` transition is seen as an edge 2–3 clk after it occurs (synchronizer delay).
  - `period_valid`, `err` and `locked` are registered, 1 clk after the rising-edge detect.
- Measured durations are in whole clk cycles. A wave with H/L of 6/6 clk measures exactly 6/6.
- `sig_in` pulses shorter than 1 clk may be missed. Missed edges show up as a bad period, never as a hang.
- Reset mid-period: all state clears immediately. The first period after release is discarded (WAIT_RISE).
- A timeout and an edge in the same cycle: the edge wins, since the count was already valid.

## Structure
- Shared package `div_mon_pkg`: state enum (WAIT_RISE, IN_HIGH, IN_LOW) and the default CNT_W.
- One sub-module, `sync2`: generic 2-flop synchronizer with asynchronous active-low reset, reusable elsewhere in the design.
- The counter, FSM and checker stay in the top module.

## Test plan
- Reset held low for 5 clk with `sig_in` toggling → all outputs stay 0. After release, the first `period_valid` comes only after a complete high plus low.
- `sig_in` 6 high / 6 low, `exp` = 6/6, TOL = 0, LOCK_CNT = 4 → `period_valid` every 12 clk, `high_len` = 6, `low_len` = 6, `locked` rises with the 4th pulse, `err` never fires.
- Locked, then one period of 7 high / 5 low → `err` pulse, `locked` drops in the same cycle, and it relocks 4 good periods later. With TOL = 1 the same period is good and the lock is held.
- `sig_in` stuck high with CNT_W = 4 → `err` pulse 15 clk after the last edge, `locked` = 0, state WAIT_RISE, no further `err` until edges resume.
- Assert `rst_n` low during IN_LOW while locked → asynchronous clear of all outputs. Recovery matches the reset scenario.
- Random `sig_in` edge jitter within ±1 clk of 9/9 with `exp` = 9/9, TOL = 1 → no `err`, and `locked` holds.
